// File: rtl/mil_mem_pkg.sv
// Shared types and default bus widths for the MIL/SPI ring-buffer memory path.
package mil_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int MEM_AW = 16;
    localparam int MEM_DW = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first asserted req at or after ptr, wrapping at N.
module rr_pick #(
    parameter int N  = 8,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    logic [PW-1:0] cand;

    // Walk N positions from ptr; the first hit wins. Wrap by compare so non-power-of-two N works.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = ptr;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
            cand = (cand == PW'(N - 1)) ? '0 : cand + PW'(1);
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one memory bus among N requesters.
// One transaction at a time; it ends on mem_ack (done) or after TIMEOUT cycles (err).
module mem_rr_arbiter
    import mil_mem_pkg::*;
#(
    parameter int N       = 8,
    parameter int AW      = MEM_AW,
    parameter int DW      = MEM_DW,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            nRst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    we,
    input  logic [N*AW-1:0] addr,
    input  logic [N*DW-1:0] wdata,
    output logic [N-1:0]    done,
    output logic [N-1:0]    err,
    output logic [DW-1:0]   rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] own_q, own_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  done_q, done_d;
    logic [N-1:0]  err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] own_nxt;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Priority moves just past the owner whether it finished or timed out.
    assign own_nxt = (own_q == PW'(N - 1)) ? '0 : own_q + PW'(1);

    // Next-state: grant in IDLE, then hold the bus until ack or timeout.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        own_d       = own_q;
        cnt_d       = cnt_q;
        done_d      = '0;
        err_d       = '0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    own_d       = pick_idx;
                    mem_we_d    = we[pick_idx];
                    mem_addr_d  = addr[pick_idx*AW +: AW];
                    mem_wdata_d = wdata[pick_idx*DW +: DW];
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                // Ack is checked first so an ack on the last allowed cycle still completes.
                if (mem_ack) begin
                    mem_req_d     = 1'b0;
                    done_d[own_q] = 1'b1;
                    rdata_d       = mem_rdata;
                    ptr_d         = own_nxt;
                    state_d       = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    mem_req_d    = 1'b0;
                    err_d[own_q] = 1'b1;
                    ptr_d        = own_nxt;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state and outputs registered; reset aborts any transaction silently.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            own_q       <= '0;
            cnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            own_q       <= own_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter (N=8, TIMEOUT=4) plus exhaustive rr_pick at N=4.
module tb_mem_rr_arbiter;

    localparam int N  = 8;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 4;

    logic            clk;
    logic            nRst;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic [DW-1:0]   rdata;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;

    logic [3:0] pk_req;
    logic [1:0] pk_ptr;
    logic       pk_valid;
    logic [1:0] pk_idx;

    int checks = 0;
    int errors = 0;

    mem_rr_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    rr_pick #(.N(4), .PW(2)) u_pick4 (
        .req   (pk_req),
        .ptr   (pk_ptr),
        .valid (pk_valid),
        .idx   (pk_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic       e_valid;
        logic [1:0] e_idx;
        int         pos;
        int         g;

        nRst = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        pk_req = '0; pk_ptr = '0;

        // rr_pick exhaustive at N=4
        for (int p = 0; p < 4; p++) begin
            for (int r = 0; r < 16; r++) begin
                pk_ptr = 2'(p);
                pk_req = 4'(r);
                #1;
                e_valid = 1'b0;
                e_idx   = 2'd0;
                for (int k = 3; k >= 0; k--) begin
                    pos = (p + k) % 4;
                    if (pk_req[pos]) begin
                        e_valid = 1'b1;
                        e_idx   = 2'(pos);
                    end
                end
                chk("pick_valid", 32'(pk_valid), 32'(e_valid));
                if (e_valid) chk("pick_idx", 32'(pk_idx), 32'(e_idx));
            end
        end

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        nRst = 1'b1;

        // stray ack in IDLE is ignored
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'h7777;
        @(negedge clk); mem_ack = 1'b0;
        chk("idle_ack_done", 32'(done), 0);
        chk("idle_ack_req", 32'(mem_req), 0);
        chk("idle_ack_rdata", 32'(rdata), 0);

        // single write on port 2, ack two cycles after mem_req
        req[2] = 1'b1; we[2] = 1'b1;
        addr[2*AW +: AW] = 16'h0010; wdata[2*DW +: DW] = 16'hBEEF;
        @(negedge clk);
        chk("wr_mem_req", 32'(mem_req), 1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h0010);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        chk("wr_mem_we", 32'(mem_we), 1);
        @(negedge clk);
        chk("wr_hold_req", 32'(mem_req), 1);
        chk("wr_no_done", 32'(done), 0);
        mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("wr_done", 32'(done), 32'h04);
        chk("wr_err", 32'(err), 0);
        chk("wr_req_fall", 32'(mem_req), 0);
        chk("wr_rdata", 32'(rdata), 32'h5A5A);
        req[2] = 1'b0;
        @(negedge clk);
        chk("wr_done_once", 32'(done), 0);
        chk("wr_idle_req", 32'(mem_req), 0);

        // read on port 5
        req[5] = 1'b1; we[5] = 1'b0; addr[5*AW +: AW] = 16'h0055;
        @(negedge clk);
        chk("rd_mem_req", 32'(mem_req), 1);
        chk("rd_mem_we", 32'(mem_we), 0);
        chk("rd_mem_addr", 32'(mem_addr), 32'h0055);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rd_done", 32'(done), 32'h20);
        chk("rd_rdata", 32'(rdata), 32'h1234);
        chk("rd_req_fall", 32'(mem_req), 0);
        req[5] = 1'b0;

        // async reset in the middle of a transaction
        @(negedge clk);
        req[6] = 1'b1; we[6] = 1'b1; addr[6*AW +: AW] = 16'h0066;
        @(negedge clk);
        chk("mid_busy_req", 32'(mem_req), 1);
        #2 nRst = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 0);
        chk("arst_mem_addr", 32'(mem_addr), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_err", 32'(err), 0);
        @(negedge clk);
        chk("arst_hold_done", 32'(done), 0);
        chk("arst_hold_err", 32'(err), 0);
        nRst = 1'b1; req = '0;

        // fairness: everyone requests, order from ptr=0 must be 0..7,0
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW] = 16'(16'h0100 + i);
            we[i] = 1'b0;
        end
        req = '1;
        for (int t = 0; t < 9; t++) begin
            g = t % N;
            @(negedge clk);
            chk("rr_grant_req", 32'(mem_req), 1);
            chk("rr_grant_addr", 32'(mem_addr), 32'h0100 + g);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            chk("rr_done", 32'(done), 32'(1) << g);
        end
        // ptr=1 now; serve 3 alone so ptr lands on 4
        req = 8'b0000_1000;
        @(negedge clk);
        chk("rr_p3_addr", 32'(mem_addr), 32'h0103);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rr_p3_done", 32'(done), 32'h08);
        req = 8'b0100_1000;
        @(negedge clk);
        chk("rr_6_first", 32'(mem_addr), 32'h0106);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rr_6_done", 32'(done), 32'h40);
        @(negedge clk);
        chk("rr_3_second", 32'(mem_addr), 32'h0103);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rr_3_done", 32'(done), 32'h08);
        req = '0;
        @(negedge clk);

        // timeout on port 1: mem_req high exactly TO cycles, then err
        req[1] = 1'b1; we[1] = 1'b1; addr[1*AW +: AW] = 16'h0011;
        mem_rdata = 16'hDEAD;
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            chk("to_req_high", 32'(mem_req), 1);
            chk("to_no_err", 32'(err), 0);
        end
        @(negedge clk);
        chk("to_req_low", 32'(mem_req), 0);
        chk("to_err", 32'(err), 32'h02);
        chk("to_no_done", 32'(done), 0);
        chk("to_rdata_kept", 32'(rdata), 32'h1234);
        // ptr should be 2: with 1 and 2 requesting, 2 wins
        req = 8'b0000_0110;

        // ack exactly on the last allowed cycle: done wins over err
        @(negedge clk);
        chk("bnd_grant", 32'(mem_addr), 32'h0102);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("bnd_still_busy", 32'(mem_req), 1);
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        @(negedge clk);
        mem_ack = 1'b0;
        req = '0;
        chk("bnd_done", 32'(done), 32'h04);
        chk("bnd_no_err", 32'(err), 0);
        chk("bnd_rdata", 32'(rdata), 32'hCAFE);
        chk("bnd_req_low", 32'(mem_req), 0);
        @(negedge clk);
        chk("bnd_quiet_done", 32'(done), 0);
        chk("bnd_quiet_err", 32'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
